// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul scratchpad writer: FSM states and
// derived-width helpers.
package matmul_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } sp_wr_state_e;

    // Number of operands per scratchpad word, i.e. largest square tile edge.
    function automatic int unsigned calc_max_dim(input int unsigned bus_w,
                                                 input int unsigned data_w);
        return bus_w / data_w;
    endfunction

    function automatic int unsigned calc_tsel_w(input int unsigned ntargets);
        return (ntargets > 1) ? $clog2(ntargets) : 1;
    endfunction

endpackage

// File: rtl/matmul_sp_writer.sv
// Streams a captured matmul result tile into a scratchpad, one word per grant.
// Define SP_WRITER_FLAGS_EN to append the overflow-flag word after the last element.
module matmul_sp_writer
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned SP_NTARGETS = 2,
    localparam int unsigned MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int unsigned TSEL_W     = calc_tsel_w(SP_NTARGETS)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   sp_write_i,
    input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   write_to_sp_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]             flags_i,
    input  logic [1:0]                             dimension_N_i,
    input  logic [1:0]                             dimension_M_i,
    input  logic [ADDR_WIDTH-1:0]                  base_addr_i,
    input  logic [TSEL_W-1:0]                      sp_target_i,
    output logic                                   sp_req_o,
    output logic [ADDR_WIDTH-1:0]                  sp_addr_o,
    output logic [BUS_WIDTH-1:0]                   sp_wdata_o,
    output logic [TSEL_W-1:0]                      sp_tsel_o,
    input  logic                                   sp_gnt_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [MAX_DIM*MAX_DIM-1:0]             flags_o,
    output logic                                   drop_o
);

    localparam int unsigned NELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned IDX_W = $clog2(NELEM + 1) + 1;

    sp_wr_state_e                  state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [IDX_W-1:0]              count_q, count_d;
    logic [BUS_WIDTH*NELEM-1:0]    data_q, data_d;
    logic [NELEM-1:0]              flags_q, flags_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [TSEL_W-1:0]             tsel_q, tsel_d;
    logic                          drop_q, drop_d;

    logic [IDX_W-1:0]              last_idx;
    logic [BUS_WIDTH-1:0]          word_sel;
    logic [BUS_WIDTH-1:0]          wdata_sel;
    logic                          in_write;

`ifdef SP_WRITER_FLAGS_EN
    // The flag word occupies index == count, one past the last element.
    logic [BUS_WIDTH-1:0] flag_word;

    always_comb begin
        flag_word = '0;
        for (int unsigned i = 0; i < NELEM && i < BUS_WIDTH; i++) begin
            flag_word[i] = flags_q[i];
        end
    end

    assign last_idx  = count_q;
    assign wdata_sel = (idx_q == count_q) ? flag_word : word_sel;
`else
    assign last_idx  = count_q - IDX_W'(1);
    assign wdata_sel = word_sel;
`endif

    assign word_sel = data_q[32'(idx_q) * BUS_WIDTH +: BUS_WIDTH];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = data_q;
        flags_d = flags_q;
        base_d  = base_q;
        tsel_d  = tsel_q;
        drop_d  = sp_write_i && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (sp_write_i) begin
                    data_d  = write_to_sp_i;
                    flags_d = flags_i;
                    base_d  = base_addr_i;
                    tsel_d  = sp_target_i;
                    count_d = IDX_W'((32'(dimension_N_i) + 32'd1) *
                                     (32'(dimension_M_i) + 32'd1));
                    idx_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (sp_gnt_i) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            flags_q <= '0;
            base_q  <= '0;
            tsel_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            base_q  <= base_d;
            tsel_q  <= tsel_d;
            drop_q  <= drop_d;
        end
    end

    // All request-side outputs are pure decodes of state registers, so they
    // stay stable across stalls and clear immediately on reset.
    assign in_write   = (state_q == StWrite);
    assign sp_req_o   = in_write;
    assign sp_addr_o  = in_write ? base_q + ADDR_WIDTH'(idx_q) : '0;
    assign sp_wdata_o = in_write ? wdata_sel : '0;
    assign sp_tsel_o  = in_write ? TSEL_W'(32'(tsel_q) % SP_NTARGETS) : '0;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign flags_o    = flags_q;
    assign drop_o     = drop_q;

endmodule

// File: tb/tb_matmul_sp_writer.sv
// Randomised bench for matmul_sp_writer against a transaction-level write-queue model.
module tb_matmul_sp_writer;
    import matmul_pkg::*;

    localparam int DW = 8;
    localparam int BW = 32;
    localparam int AW = 16;
    localparam int NT = 2;
    localparam int MD = int'(calc_max_dim(BW, DW));
    localparam int NE = MD * MD;
    localparam int TW = int'(calc_tsel_w(NT));
`ifdef SP_WRITER_FLAGS_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [TW-1:0] tsel;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sp_write = 1'b0;
    logic [BW*NE-1:0]  wdata_in = '0;
    logic [NE-1:0]     flags_in = '0;
    logic [1:0]        dim_n = '0;
    logic [1:0]        dim_m = '0;
    logic [AW-1:0]     base_in = '0;
    logic [TW-1:0]     tgt_in = '0;
    logic              gnt = 1'b0;
    logic              sp_req;
    logic [AW-1:0]     sp_addr;
    logic [BW-1:0]     sp_wdata;
    logic [TW-1:0]     sp_tsel;
    logic              busy, done, drop;
    logic [NE-1:0]     flags_out;

    matmul_sp_writer #(
        .DATA_WIDTH  (DW),
        .BUS_WIDTH   (BW),
        .ADDR_WIDTH  (AW),
        .SP_NTARGETS (NT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sp_write_i    (sp_write),
        .write_to_sp_i (wdata_in),
        .flags_i       (flags_in),
        .dimension_N_i (dim_n),
        .dimension_M_i (dim_m),
        .base_addr_i   (base_in),
        .sp_target_i   (tgt_in),
        .sp_req_o      (sp_req),
        .sp_addr_o     (sp_addr),
        .sp_wdata_o    (sp_wdata),
        .sp_tsel_o     (sp_tsel),
        .sp_gnt_i      (gnt),
        .busy_o        (busy),
        .done_o        (done),
        .flags_o       (flags_out),
        .drop_o        (drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gmode = 0;
    int pc = 0;
    int done_cyc = -1;
    bit chk_en = 1'b0;

    wr_t           mq[$];
    bit            m_done = 1'b0;
    bit            m_drop = 1'b0;
    logic [NE-1:0] m_flags = '0;

    logic [AW-1:0] acc_addr[$];
    logic [BW-1:0] acc_data[$];
    int            acc_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (gmode)
            0:       gnt = 1'b1;
            1:       gnt = ~gnt;
            default: gnt = 1'($urandom_range(0, 1));
        endcase
    end

    // Model: a matrix pulse in idle enqueues every word the DUT owes; each
    // grant retires the head; emptying the queue yields one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_done = 1'b0;
            m_drop = 1'b0;
            m_flags = '0;
        end else begin
            bit busy_pre, nd, ndrop;
            int cnt;
            wr_t w;
            busy_pre = (mq.size() != 0) || m_done;
            nd = 1'b0;
            ndrop = sp_write && busy_pre;
            if (mq.size() != 0 && gnt) begin
                mq.delete(0);
                if (mq.size() == 0) nd = 1'b1;
            end
            if (sp_write && !busy_pre) begin
                cnt = (int'(dim_n) + 1) * (int'(dim_m) + 1);
                for (int e = 0; e < cnt; e++) begin
                    w.addr = base_in + AW'(e);
                    w.data = wdata_in[e*BW +: BW];
                    w.tsel = TW'(int'(tgt_in) % NT);
                    mq.push_back(w);
                end
`ifdef SP_WRITER_FLAGS_EN
                w.addr = base_in + AW'(cnt);
                w.data = BW'(flags_in);
                w.tsel = TW'(int'(tgt_in) % NT);
                mq.push_back(w);
`endif
                m_flags = flags_in;
            end
            m_done = nd;
            m_drop = ndrop;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            bit er;
            er = (mq.size() != 0);
            check("req", sp_req, er);
            check("addr", sp_addr, er ? mq[0].addr : '0);
            check("wdata", sp_wdata, er ? mq[0].data : '0);
            check("tsel", sp_tsel, er ? mq[0].tsel : '0);
            check("busy", busy, er || m_done);
            check("done", done, m_done);
            check("drop", drop, m_drop);
            check("flags", flags_out, m_flags);
            if (sp_req && gnt) begin
                acc_addr.push_back(sp_addr);
                acc_data.push_back(sp_wdata);
                acc_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic clear_log();
        acc_addr.delete();
        acc_data.delete();
        acc_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic pulse(input int n, input int m, input logic [AW-1:0] base,
                         input int tgt, input logic [NE-1:0] fl);
        @(posedge clk);
        #1;
        for (int e = 0; e < NE; e++) wdata_in[e*BW +: BW] = $urandom;
        flags_in = fl;
        dim_n = 2'(n);
        dim_m = 2'(m);
        base_in = base;
        tgt_in = TW'(tgt);
        sp_write = 1'b1;
        pc = cyc;
        @(posedge clk);
        #1;
        sp_write = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((mq.size() != 0 || m_done) && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("idle_timeout", ((mq.size() != 0) || m_done) ? 1 : 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] w0;
        logic [AW-1:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", sp_req, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", sp_addr, 0);
        check("rst_flags", flags_out, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // 2x2 at 0x0100, grant tied high
        gmode = 0;
        clear_log();
        pulse(1, 1, 16'h0100, 1, 16'h00A5);
        wait_idle();
        check("t1_count", acc_addr.size(), 4 + XTRA);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", acc_addr[i], 16'h0100 + i);
            check("t1_cyc", acc_cyc[i], pc + 1 + i);
        end
        check("t1_done_cyc", done_cyc, pc + 5 + XTRA);
        check("t1_flags", flags_out, 16'h00A5);

        // 4x4, grant toggling
        gmode = 1;
        clear_log();
        pulse(3, 3, 16'h2000, 0, 16'hFFFF);
        wait_idle();
        check("t2_count", acc_addr.size(), 16 + XTRA);
        check("t2_last_addr", acc_addr[15], 16'h200F);

        // address wrap
        gmode = 0;
        clear_log();
        pulse(1, 1, 16'hFFFE, 0, '0);
        wait_idle();
        check("t3_a0", acc_addr[0], 16'hFFFE);
        check("t3_a1", acc_addr[1], 16'hFFFF);
        check("t3_a2", acc_addr[2], 16'h0000);
        check("t3_a3", acc_addr[3], 16'h0001);

        // pulse during a transfer is dropped
        gmode = 1;
        clear_log();
        pulse(1, 1, 16'h0300, 1, 16'h0003);
        w0 = wdata_in[BW-1:0];
        pulse(3, 3, 16'h0700, 0, 16'h1234);
        check("t4_drop", drop, 1);
        wait_idle();
        check("t4_count", acc_addr.size(), 4 + XTRA);
        check("t4_data0", acc_data[0], w0);
        check("t4_flags", flags_out, 16'h0003);

        // asynchronous reset while the third word is on the bus
        gmode = 0;
        clear_log();
        pulse(1, 1, 16'h0400, 1, 16'h0001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_pre_addr", sp_addr, 16'h0402);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_req", sp_req, 0);
        check("t5_busy", busy, 0);
        check("t5_addr", sp_addr, 0);
        check("t5_wdata", sp_wdata, 0);
        check("t5_flags", flags_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        pulse(1, 1, 16'h0500, 0, '0);
        wait_idle();
        check("t5_restart_addr", acc_addr[0], 16'h0500);
        check("t5_restart_cnt", acc_addr.size(), 4 + XTRA);

        // 3x2 with flags 0x0005
        clear_log();
        pulse(2, 1, 16'h0600, 0, 16'h0005);
        wait_idle();
        check("t6_count", acc_addr.size(), 6 + XTRA);
        check("t6_flags", flags_out, 16'h0005);
`ifdef SP_WRITER_FLAGS_EN
        check("t6_flag_addr", acc_addr[6], 16'h0606);
        check("t6_flag_word", acc_data[6], 32'h0000_0005);
`endif

        // random traffic
        gmode = 2;
        for (int t = 0; t < 40; t++) begin
            b = AW'($urandom);
            pulse($urandom_range(0, 3), $urandom_range(0, 3), b,
                  $urandom_range(0, (1 << TW) - 1), NE'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                pulse($urandom_range(0, 3), $urandom_range(0, 3), AW'($urandom), 0,
                      NE'($urandom));
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
